// File: rtl/spi_master_byte.sv
// Byte-stream SPI master, mode 0, MSB first.
// Tx bytes arrive on an AXI-Stream-style slave port; the byte clocked in on MISO during
// the same transfer is returned as a one-cycle pulse on the master port. tlast on the
// tx byte releases chip select once that byte has been shifted.
module spi_master_byte #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2,
    parameter int unsigned CS_IDLE  = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       s_axis_tlast,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    output logic       o_spi_clk,
    output logic       o_spi_mosi,
    input  logic       i_spi_miso,
    output logic       o_spi_cs_n,
    output logic       o_busy
);

    localparam int unsigned CntW = 16;
    localparam logic [CntW-1:0] DivLast   = CntW'(CLK_DIV - 1);
    localparam logic [CntW-1:0] SetupLast = CntW'(CS_SETUP - 1);
    localparam logic [CntW-1:0] HoldLast  = CntW'(CS_HOLD - 1);
    localparam logic [CntW-1:0] IdleLast  = CntW'(CS_IDLE - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StWait,
        StHold,
        StDesel
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;     // shared phase counter: setup, half-period, hold, idle
    logic [4:0]      half_q, half_d;   // completed SCLK half-periods of the current byte
    logic [7:0]      tx_q, tx_d;       // MSB drives MOSI; shifts left on each falling edge
    logic [7:0]      rx_q, rx_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            rvalid_q, rvalid_d;
    logic            last_q, last_d;
    logic            sclk_q, sclk_d;
    logic            cs_n_q, cs_n_d;
    logic            accept;
    logic            wrap;

    // Tready is gated by reset so nothing is accepted while the FSM is being cleared.
    assign s_axis_tready = ((state_q == StIdle) || (state_q == StWait)) && !i_rst;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign wrap          = (cnt_q == DivLast);

    assign o_spi_clk     = sclk_q;
    assign o_spi_mosi    = tx_q[7];
    assign o_spi_cs_n    = cs_n_q;
    assign m_axis_tdata  = rdata_q;
    assign m_axis_tvalid = rvalid_q;
    assign o_busy        = (state_q != StIdle);

    // Next-state logic: transaction sequencing, SCLK generation and shift registers.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        half_d   = half_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        last_d   = last_q;
        sclk_d   = sclk_q;
        cs_n_d   = cs_n_q;

        unique case (state_q)
            StIdle: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b0;
                if (accept) begin
                    tx_d    = s_axis_tdata;
                    last_d  = s_axis_tlast;
                    cnt_d   = '0;
                    cs_n_d  = 1'b0;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (cnt_q == SetupLast) begin
                    cnt_d   = '0;
                    half_d  = '0;
                    state_d = StShift;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StShift: begin
                if (half_q == 5'd16) begin
                    // Pulse cycle: the rx byte is presented while still in SHIFT, so a
                    // WAIT accept can never coincide with m_axis_tvalid.
                    cnt_d   = '0;
                    state_d = last_q ? StHold : StWait;
                end else if (wrap) begin
                    cnt_d  = '0;
                    sclk_d = ~sclk_q;
                    half_d = half_q + 5'd1;
                    if (!sclk_q) begin
                        rx_d = {rx_q[6:0], i_spi_miso};
                    end else begin
                        tx_d = {tx_q[6:0], 1'b0};
                        if (half_q == 5'd15) begin
                            rdata_d  = rx_q;
                            rvalid_d = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWait: begin
                sclk_d = 1'b0;
                if (accept) begin
                    tx_d    = s_axis_tdata;
                    last_d  = s_axis_tlast;
                    cnt_d   = '0;
                    half_d  = '0;
                    state_d = StShift;
                end
            end
            StHold: begin
                if (cnt_q == HoldLast) begin
                    cnt_d   = '0;
                    cs_n_d  = 1'b1;
                    state_d = StDesel;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDesel: begin
                if (cnt_q == IdleLast) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; synchronous reset aborts any transfer in progress.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            half_q   <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            last_q   <= 1'b0;
            sclk_q   <= 1'b0;
            cs_n_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            half_q   <= half_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            last_q   <= last_d;
            sclk_q   <= sclk_d;
            cs_n_q   <= cs_n_d;
        end
    end

endmodule

// File: tb/tb_spi_master_byte.sv
// Bench for spi_master_byte: instance A (CLK_DIV=2) against a mode-0 slave model,
// instance B (all timing parameters 1) in MISO=MOSI loopback with a random stream.
module tb_spi_master_byte;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [7:0] a_tx_data;
    logic       a_tx_valid, a_tx_last, a_tx_ready;
    logic [7:0] a_rx_data;
    logic       a_rx_valid, a_sclk, a_mosi, a_miso, a_cs_n, a_busy;

    logic [7:0] b_tx_data;
    logic       b_tx_valid, b_tx_last, b_tx_ready;
    logic [7:0] b_rx_data;
    logic       b_rx_valid, b_sclk, b_mosi, b_miso, b_cs_n, b_busy;

    assign b_miso = b_mosi;

    spi_master_byte #(
        .CLK_DIV (2),
        .CS_SETUP(2),
        .CS_HOLD (2),
        .CS_IDLE (4)
    ) u_dut_a (
        .i_clk        (clk),
        .i_rst        (rst),
        .s_axis_tdata (a_tx_data),
        .s_axis_tvalid(a_tx_valid),
        .s_axis_tready(a_tx_ready),
        .s_axis_tlast (a_tx_last),
        .m_axis_tdata (a_rx_data),
        .m_axis_tvalid(a_rx_valid),
        .o_spi_clk    (a_sclk),
        .o_spi_mosi   (a_mosi),
        .i_spi_miso   (a_miso),
        .o_spi_cs_n   (a_cs_n),
        .o_busy       (a_busy)
    );

    spi_master_byte #(
        .CLK_DIV (1),
        .CS_SETUP(1),
        .CS_HOLD (1),
        .CS_IDLE (1)
    ) u_dut_b (
        .i_clk        (clk),
        .i_rst        (rst),
        .s_axis_tdata (b_tx_data),
        .s_axis_tvalid(b_tx_valid),
        .s_axis_tready(b_tx_ready),
        .s_axis_tlast (b_tx_last),
        .m_axis_tdata (b_rx_data),
        .m_axis_tvalid(b_rx_valid),
        .o_spi_clk    (b_sclk),
        .o_spi_mosi   (b_mosi),
        .i_spi_miso   (b_miso),
        .o_spi_cs_n   (b_cs_n),
        .o_busy       (b_busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Byte the slave model returns for the k-th byte it is asked for.
    function automatic logic [7:0] slv_byte(input int k);
        return 8'((k * 37 + 60) & 255);
    endfunction

    logic [7:0] a_exp_rx[$];
    logic [7:0] a_exp_tx[$];
    logic [7:0] b_exp_rx[$];
    int         tx_idx = 0;

    // Slave model and monitor for instance A.
    logic       a_sclk_prev = 1'b0;
    logic       a_cs_prev   = 1'b1;
    bit         a_rst_seen  = 1'b1;
    int         a_rises = 0, a_low = 0, a_high = 0, a_last_rises = 0, a_last_low = 0;
    int         a_rib = 0, a_fib = 0, a_slave_idx = 0;
    logic [7:0] a_sh = '0, a_mos = '0;

    initial a_miso = 1'b0;

    always @(negedge clk) begin
        if (rst) a_rst_seen = 1'b1;
        if (a_rx_valid === 1'b1) begin
            check("rx_a_pending", a_exp_rx.size() != 0, 1);
            if (a_exp_rx.size() != 0) check("rx_a", a_rx_data, a_exp_rx.pop_front());
        end
        if (a_cs_n === 1'b1) begin
            if (a_cs_prev === 1'b0) begin
                a_last_rises = a_rises;
                a_last_low   = a_low;
                a_high       = 0;
            end
            a_high++;
            a_miso = 1'b0;
            a_rib  = 0;
            a_fib  = 0;
        end else if (a_cs_n === 1'b0) begin
            if (a_cs_prev === 1'b1) begin
                if (!a_rst_seen) check("cs_idle_gap", a_high >= 4, 1);
                a_rst_seen = 1'b0;
                a_rises    = 0;
                a_low      = 0;
                a_sh       = slv_byte(a_slave_idx);
                a_miso     = a_sh[7];
            end
            a_low++;
            if (a_sclk && !a_sclk_prev) begin
                if (a_rib == 0) a_slave_idx++;
                a_mos = {a_mos[6:0], a_mosi};
                a_rises++;
                a_rib++;
                if (a_rib == 8) begin
                    a_rib = 0;
                    check("mosi_a_pending", a_exp_tx.size() != 0, 1);
                    if (a_exp_tx.size() != 0) check("mosi_a", a_mos, a_exp_tx.pop_front());
                end
            end
            if (!a_sclk && a_sclk_prev) begin
                a_fib++;
                if (a_fib == 8) begin
                    a_fib = 0;
                    a_sh  = slv_byte(a_slave_idx);
                end else begin
                    a_sh = a_sh << 1;
                end
                a_miso = a_sh[7];
            end
        end
        a_sclk_prev = a_sclk;
        a_cs_prev   = a_cs_n;
    end

    // Monitor for instance B: rx scoreboard plus SCLK phase / MOSI stability errors.
    logic b_sclk_prev = 1'b0;
    logic b_mosi_prev = 1'b0;
    int   b_ph = 0, b_rib = 0, b_err = 0;

    always @(negedge clk) begin
        if (b_rx_valid === 1'b1) begin
            check("rx_b_pending", b_exp_rx.size() != 0, 1);
            if (b_exp_rx.size() != 0) check("rx_b", b_rx_data, b_exp_rx.pop_front());
        end
        if (b_cs_n !== 1'b0) begin
            b_rib = 0;
        end else begin
            if (b_sclk != b_sclk_prev) begin
                if (b_sclk) begin
                    if ((b_rib % 8) != 0 && b_ph != 1) b_err++;
                    b_rib++;
                end else if (b_ph != 1) begin
                    b_err++;
                end
                b_ph = 1;
            end else begin
                b_ph++;
            end
            if (b_mosi != b_mosi_prev && b_sclk) b_err++;
        end
        b_sclk_prev = b_sclk;
        b_mosi_prev = b_mosi;
    end

    task automatic send_a(input logic [7:0] d, input logic last, input bit good, output int lat);
        int n;
        @(negedge clk);
        a_tx_data  = d;
        a_tx_last  = last;
        a_tx_valid = 1'b1;
        n = 0;
        while (!a_tx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("send_a_tready", a_tx_ready, 1);
        if (good) begin
            a_exp_tx.push_back(d);
            a_exp_rx.push_back(slv_byte(tx_idx));
        end
        tx_idx++;
        @(negedge clk);
        a_tx_valid = 1'b0;
        // Cycles counted from the one following the accept edge to first SCLK high.
        lat = 1;
        while (!a_sclk && lat < 500) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic wait_cs_a();
        int n;
        n = 0;
        while (!a_cs_n && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("cs_release", a_cs_n, 1);
        @(negedge clk);
    endtask

    task automatic send_b(input logic [7:0] d, input logic last);
        int n;
        int gap;
        gap = $urandom_range(0, 3);
        for (int g = 0; g <= gap; g++) @(negedge clk);
        b_tx_data  = d;
        b_tx_last  = last;
        b_tx_valid = 1'b1;
        n = 0;
        while (!b_tx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("send_b_tready", b_tx_ready, 1);
        b_exp_rx.push_back(d);
        @(negedge clk);
        b_tx_valid = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int lat;
        int n;
        int bad;
        logic prev;

        rst        = 1'b1;
        a_tx_data  = '0;
        a_tx_valid = 1'b0;
        a_tx_last  = 1'b0;
        b_tx_data  = '0;
        b_tx_valid = 1'b0;
        b_tx_last  = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_cs_n", a_cs_n, 1);
        check("rst_sclk", a_sclk, 0);
        check("rst_mosi", a_mosi, 0);
        check("rst_rvalid", a_rx_valid, 0);
        check("rst_rdata", a_rx_data, 0);
        check("rst_tready", a_tx_ready, 0);
        check("rst_busy", a_busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_tready", a_tx_ready, 1);

        // Single byte 0xA5 / slave 0x3C
        send_a(8'hA5, 1'b1, 1'b1, lat);
        check("t1_lat", lat, 5);
        check("t1_busy", a_busy, 1);
        wait_cs_a();
        check("t1_rises", a_last_rises, 8);
        check("t1_cs_low", a_last_low, 37);

        // Three-byte transaction
        send_a(8'h01, 1'b0, 1'b1, lat);
        send_a(8'h02, 1'b0, 1'b1, lat);
        send_a(8'h83, 1'b1, 1'b1, lat);
        wait_cs_a();
        check("t2_rises", a_last_rises, 24);

        // Stall in WAIT, then continue
        send_a(8'h55, 1'b0, 1'b1, lat);
        n = 0;
        while (!a_tx_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("t3_wait_state", a_tx_ready, 1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_cs_n !== 1'b0 || a_sclk !== 1'b0 || a_tx_ready !== 1'b1) bad++;
        end
        check("t3_wait_hold", bad, 0);
        send_a(8'hFF, 1'b1, 1'b1, lat);
        check("t3_lat", lat, 3);
        wait_cs_a();
        check("t3_rises", a_last_rises, 16);

        // Reset at 5th rise of 0xC3
        send_a(8'hC3, 1'b1, 1'b0, lat);
        n    = 1;
        prev = a_sclk;
        bad  = 0;
        while (n < 5 && bad < 500) begin
            @(negedge clk);
            if (a_sclk && !prev) n++;
            prev = a_sclk;
            bad++;
        end
        check("t4_fifth_rise", n, 5);
        rst = 1'b1;
        @(negedge clk);
        check("t4_abort_cs_n", a_cs_n, 1);
        check("t4_abort_sclk", a_sclk, 0);
        check("t4_abort_tready", a_tx_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        send_a(8'h12, 1'b1, 1'b1, lat);
        check("t4_lat", lat, 5);
        wait_cs_a();
        check("t4_rises", a_last_rises, 8);

        // Loopback random stream on instance B
        for (int i = 0; i < 256; i++) begin
            send_b(8'($urandom_range(0, 255)), (i == 255) || ($urandom_range(0, 7) == 0));
        end
        n = 0;
        while (b_exp_rx.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        check("b_rx_left", b_exp_rx.size(), 0);
        check("b_phase_err", b_err, 0);
        check("b_cs_end", b_cs_n, 1);
        check("a_rx_left", a_exp_rx.size(), 0);
        check("a_tx_left", a_exp_tx.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
